fifo_rd_stream: RTL and testbench



---
 rtl/fifo_rd_stream.sv | 102 ++++++++++
 tb/tb_fifo_rd_stream.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side drain engine for a first-word-fall-through FIFO.
// Pops FIFO entries into a 2-entry output/skid buffer and presents them as a
// registered valid/ready stream, flagging every BURST_LEN-th accepted beat
// with out_last. The pop decision never looks at out_ready, so there is no
// combinational path from the downstream consumer back into the FIFO.
//
// Optional build macro FIFO_RD_STREAM_STATS_EN adds saturating 32-bit
// xfer_cnt (accepted beats) and stall_cnt (valid-but-not-ready cycles).
module fifo_rd_stream #(
  parameter int WIDTH     = 31,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             fifo_rd_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [1:0]       buf_cnt
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [31:0]      xfer_cnt,
  output logic [31:0]      stall_cnt
`endif
);

  localparam int BCNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BCNT_W-1:0] BEAT_LAST = BCNT_W'(BURST_LEN - 1);

  logic [WIDTH-1:0]  slot0;
  logic [WIDTH-1:0]  slot1;
  // Beats remaining before the burst boundary; the boundary beat is at zero.
  logic [BCNT_W-1:0] beats_left;
  logic              pop;
  logic              acc;

  // Buffer occupancy alone gates the pop; buf_cnt never reaches 3.
  assign pop        = en & ~flush & ~rst & ~fifo_empty & (buf_cnt != 2'd2);
  assign fifo_rd_en = pop;
  assign out_valid  = (buf_cnt != 2'd0);
  assign acc        = out_valid & out_ready;
  assign out_data   = slot0;
  assign out_last   = out_valid & (beats_left == '0);

  // Output/skid buffer: slot0 is the presented beat, slot1 catches the pop
  // that lands while slot0 is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot0   <= '0;
      slot1   <= '0;
      buf_cnt <= 2'd0;
    end else if (flush) begin
      buf_cnt <= 2'd0;
    end else begin
      case ({pop, acc})
        2'b10: begin
          if (buf_cnt == 2'd0) slot0 <= fifo_rd_data;
          else                 slot1 <= fifo_rd_data;
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          slot0   <= slot1;
          buf_cnt <= buf_cnt - 2'd1;
        end
        // Only reachable with buf_cnt=1: replace the leaving beat in place.
        2'b11: slot0 <= fifo_rd_data;
        default: ;
      endcase
    end
  end

  // Burst position as a down-counter reloaded after the boundary beat.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      beats_left <= BEAT_LAST;
    end else if (acc) begin
      if (beats_left == '0) beats_left <= BEAT_LAST;
      else                  beats_left <= beats_left - BCNT_W'(1);
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  // Saturating event counters; flush leaves them untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (acc && (xfer_cnt != '1))
        xfer_cnt <= xfer_cnt + 32'd1;
      if (out_valid && !out_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a queue-based FIFO model feeds the
// DUT, popped entries are pushed to an in-flight queue, and a negedge monitor
// checks every presented/accepted beat against that queue and a beat index.
module tb_fifo_rd_stream;

  localparam int WIDTH     = 31;
  localparam int BURST_LEN = 4;

  logic             clk;
  logic             rst;
  logic             en;
  logic             flush;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rd_data;
  logic             fifo_rd_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic [1:0]       buf_cnt;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0]      xfer_cnt;
  logic [31:0]      stall_cnt;
`endif

  fifo_rd_stream #(.WIDTH(WIDTH), .BURST_LEN(BURST_LEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .flush        (flush),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .buf_cnt      (buf_cnt)
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    .xfer_cnt     (xfer_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] fifo_q[$];   // contents of the upstream FIFO
  logic [WIDTH-1:0] sb_q[$];     // popped but not yet accepted, in order
  int               beat_idx = 0;
  logic             pop_seen = 1'b0;
  logic             started  = 1'b0;
  logic             rst_prev = 1'b0;
  longint           m_xfer   = 0;
  longint           m_stall  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: compare at negedge, then advance the reference model for the
  // posedge that follows (inputs are stable from posedge+2 to next posedge).
  always @(negedge clk) begin
    logic exp_rd_en;
    logic m_valid;
    logic m_acc;
    if (started) begin
      m_valid   = (sb_q.size() != 0);
      exp_rd_en = en & ~flush & ~rst & (fifo_q.size() != 0) & (sb_q.size() < 2);
      m_acc     = m_valid & out_ready;

      chk("fifo_rd_en", 64'(fifo_rd_en), 64'(exp_rd_en));
      chk("out_valid",  64'(out_valid),  64'(m_valid));
      chk("buf_cnt",    64'(buf_cnt),    64'(sb_q.size()));
      if (m_valid) begin
        chk("out_data", 64'(out_data), 64'(sb_q[0]));
        chk("out_last", 64'(out_last), 64'(beat_idx == BURST_LEN - 1));
      end else begin
        chk("out_last_idle", 64'(out_last), 64'd0);
      end
      if (rst_prev) chk("out_data_reset", 64'(out_data), 64'd0);
`ifdef FIFO_RD_STREAM_STATS_EN
      chk("xfer_cnt",  64'(xfer_cnt),  64'(m_xfer));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif

      if (rst) begin
        sb_q.delete();
        beat_idx = 0;
        m_xfer   = 0;
        m_stall  = 0;
      end else begin
        if (m_acc) m_xfer++;
        if (m_valid && !out_ready) m_stall++;
        if (flush) begin
          sb_q.delete();
          beat_idx = 0;
        end else begin
          if (m_acc) begin
            void'(sb_q.pop_front());
            beat_idx = (beat_idx + 1) % BURST_LEN;
          end
          if (exp_rd_en) sb_q.push_back(fifo_q[0]);
        end
      end
      pop_seen = exp_rd_en;
      rst_prev = rst;
    end
  end

  // Advance one cycle and retire the entry the DUT popped at that posedge.
  task automatic next_cycle();
    @(posedge clk);
    #2;
    if (pop_seen && fifo_q.size() != 0) void'(fifo_q.pop_front());
    pop_seen = 1'b0;
  endtask

  task automatic drive_fifo();
    fifo_empty   = (fifo_q.size() == 0);
    fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    int mode;
    rst = 1'b1; en = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive_fifo();
    next_cycle();
    started = 1'b1;
    next_cycle();

    // Directed stream: 1..8 with the consumer always ready.
    rst = 1'b0; en = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) fifo_q.push_back(WIDTH'(i));
    drive_fifo();
    repeat (12) begin
      next_cycle();
      drive_fifo();
    end

    // Randomized traffic with modes biasing backpressure, gating and flush.
    for (int c = 0; c < 4000; c++) begin
      next_cycle();
      mode      = (c / 250) % 4;
      out_ready = (mode == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      en        = (mode == 2) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 9) != 0);
      flush     = (mode == 3) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 59) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      if (fifo_q.size() < 6 && $urandom_range(0, 2) != 0) begin
        d = WIDTH'($urandom());
        fifo_q.push_back(d);
      end
      drive_fifo();
    end

    // Drain: no new pops, consumer ready; buffer must empty in bounded time.
    next_cycle();
    rst = 1'b0; flush = 1'b0; en = 1'b0; out_ready = 1'b1;
    drive_fifo();
    for (int k = 0; k < 10 && sb_q.size() != 0; k++) begin
      next_cycle();
      drive_fifo();
    end
    next_cycle();
    chk("drain_empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
